// File: rtl/matrix_ls_sequencer.sv
// Row-by-row matrix load/store sequencer between the matrix LS unit, a single-ported memory and the matrix RF.
// Optional MLS_ZERO_STRIDE_BCAST_EN: zero-stride loads read row 0 once and broadcast it to the remaining rows.
module matrix_ls_sequencer #(
  parameter int MAT_DIM = 4,
  parameter int ROW_W   = 64,
  parameter int ADDR_W  = 32,
  parameter int MREG_W  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_ls,
  input  logic [MREG_W-1:0]          req_mreg,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [ADDR_W-1:0]          req_stride,
  output logic                       mem_ren,
  output logic                       mem_wen,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [ROW_W-1:0]           mem_wdata,
  input  logic [ROW_W-1:0]           mem_rdata,
  input  logic                       mem_ready,
  output logic                       mrf_wen,
  output logic [MREG_W-1:0]          mrf_widx,
  output logic [$clog2(MAT_DIM)-1:0] mrf_wrow,
  output logic [ROW_W-1:0]           mrf_wdata,
  output logic [MREG_W-1:0]          mrf_ridx,
  output logic [$clog2(MAT_DIM)-1:0] mrf_rrow,
  input  logic [ROW_W-1:0]           mrf_rdata,
  output logic                       mhit,
  output logic                       busy
);
  localparam int ROW_IW = $clog2(MAT_DIM);
  localparam logic [ROW_IW-1:0] LAST_ROW = ROW_IW'(MAT_DIM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t              state, state_nxt;
  logic [MREG_W-1:0]   mreg_q;
  logic [ADDR_W-1:0]   addr_q, stride_q;
  logic [ROW_IW-1:0]   row_q;
  logic                accept, advance;

`ifdef MLS_ZERO_STRIDE_BCAST_EN
  logic [ROW_W-1:0]    bcast_q;
  logic                bcast;
  // Rows after row 0 of a zero-stride load come from the captured row, not memory.
  assign bcast = (stride_q == '0) && (row_q != '0);
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    req_ready = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mrf_wen   = 1'b0;
    mrf_widx  = '0;
    mrf_wrow  = '0;
    mrf_wdata = '0;
    mrf_ridx  = '0;
    mrf_rrow  = '0;
    mhit      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && req_ls != 2'b00) begin
          accept    = 1'b1;
          state_nxt = req_ls[0] ? LOAD : STORE;
        end
      end
      LOAD: begin
`ifdef MLS_ZERO_STRIDE_BCAST_EN
        if (bcast) begin
          mrf_wen   = 1'b1;
          mrf_widx  = mreg_q;
          mrf_wrow  = row_q;
          mrf_wdata = bcast_q;
          advance   = 1'b1;
        end else
`endif
        begin
          mem_ren  = 1'b1;
          mem_addr = addr_q;
          if (mem_ready) begin
            mrf_wen   = 1'b1;
            mrf_widx  = mreg_q;
            mrf_wrow  = row_q;
            mrf_wdata = mem_rdata;
            advance   = 1'b1;
          end
        end
      end
      STORE: begin
        mrf_ridx  = mreg_q;
        mrf_rrow  = row_q;
        mem_wen   = 1'b1;
        mem_wdata = mrf_rdata;
        mem_addr  = addr_q;
        advance   = mem_ready;
      end
      DONE: begin
        mhit      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (advance && row_q == LAST_ROW) state_nxt = DONE;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      mreg_q   <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      row_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mreg_q   <= req_mreg;
        addr_q   <= req_addr;
        stride_q <= req_stride;
        row_q    <= '0;
      end else if (advance) begin
        row_q  <= row_q + 1'b1;
        addr_q <= addr_q + stride_q;
      end
    end
  end

`ifdef MLS_ZERO_STRIDE_BCAST_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      bcast_q <= '0;
    else if (state == LOAD && row_q == '0 && mem_ready)
      bcast_q <= mem_rdata;
  end
`endif

endmodule
